// File: rtl/bridge_arb_pkg.sv
// Shared types and default widths for the peripheral bridge arbiter.
package bridge_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request found searching upward
// from i_ptr+1 with wrap-around.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any_req
);

  int w_dist;
  int w_best;

  // Each requester is ranked by its distance past the pointer; smallest wins.
  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    w_dist    = 0;
    w_best    = N;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + N - 1 - int'(i_ptr)) % N;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best    = w_dist;
        o_winner  = IDX_W'(j);
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing the single-master peripheral bridge between masters.
// Optional master lock build option: BRIDGE_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | waiting for a request; winner and its command latched on exit
// ISSUE | latched command driven onto the bridge, read data captured
// ACK   | one-cycle ack to the winner, round-robin pointer advanced
module bridge_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_MASTERS-1:0]        io_m_req,
  input  logic [N_MASTERS-1:0]        io_m_write,
  input  logic [N_MASTERS*ADDR_W-1:0] io_m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] io_m_wdata,
`ifdef BRIDGE_ARB_LOCK_EN
  input  logic [N_MASTERS-1:0]        io_m_lock,
`endif
  output logic [N_MASTERS-1:0]        io_m_ack,
  output logic [DATA_W-1:0]           io_m_rdata,
  output logic                        io_busy,
  output logic [DATA_W-1:0]           io_bus_in_data,
  output logic                        io_bus_write,
  output logic [ADDR_W-1:0]           io_bus_address,
  input  logic [DATA_W-1:0]           io_bus_out_data
);

  localparam int IDX_W = $clog2(N_MASTERS);

  arb_state_t           r_state, w_next;
  logic [IDX_W-1:0]     r_ptr, r_win, w_winner;
  logic                 w_any_req;
  logic [N_MASTERS-1:0] w_req_eff;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_write;

`ifdef BRIDGE_ARB_LOCK_EN
  logic r_locked;

  // A held lock narrows the candidates to the previous winner, if it still asks.
  always_comb begin
    w_req_eff = io_m_req;
    if (r_locked && io_m_req[r_ptr]) begin
      w_req_eff        = '0;
      w_req_eff[r_ptr] = 1'b1;
    end
  end
`else
  assign w_req_eff = io_m_req;
`endif

  rr_pick #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req     (w_req_eff),
    .i_ptr     (r_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  always_comb begin
    w_next         = r_state;
    io_m_ack       = '0;
    io_bus_write   = 1'b0;
    io_bus_address = '0;
    io_bus_in_data = '0;
    case (r_state)
      IDLE:  if (w_any_req) w_next = ISSUE;
      ISSUE: begin
        w_next         = ACK;
        io_bus_address = r_addr;
        io_bus_in_data = r_wdata;
        io_bus_write   = r_write & ~reset;
      end
      ACK: begin
        w_next = IDLE;
        if (!reset) io_m_ack[r_win] = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= IDX_W'(N_MASTERS - 1);
      r_win   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_rdata <= '0;
`ifdef BRIDGE_ARB_LOCK_EN
      r_locked <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_win   <= w_winner;
            r_addr  <= io_m_addr[w_winner*ADDR_W +: ADDR_W];
            r_wdata <= io_m_wdata[w_winner*DATA_W +: DATA_W];
            r_write <= io_m_write[w_winner];
          end
`ifdef BRIDGE_ARB_LOCK_EN
          r_locked <= 1'b0;
`endif
        end
        ISSUE: r_rdata <= io_bus_out_data;
        ACK: begin
          r_ptr <= r_win;
`ifdef BRIDGE_ARB_LOCK_EN
          r_locked <= io_m_lock[r_win];
`endif
        end
        default: ;
      endcase
    end
  end

  assign io_busy    = (r_state != IDLE);
  assign io_m_rdata = r_rdata;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench for bridge_arbiter with a small bridge model: addr 0 is a
// writable register, addr 4 reads the constant 0x539.
module tb_bridge_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_req;
  logic [1:0]  m_write;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
`ifdef BRIDGE_ARB_LOCK_EN
  logic [1:0]  m_lock;
`endif
  logic [1:0]  io_m_ack;
  logic [31:0] io_m_rdata;
  logic        io_busy;
  logic [31:0] io_bus_in_data;
  logic        io_bus_write;
  logic [31:0] io_bus_address;
  logic [31:0] io_bus_out_data;
  logic [31:0] r_periph;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bridge_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .io_m_req        (m_req),
    .io_m_write      (m_write),
    .io_m_addr       (m_addr),
    .io_m_wdata      (m_wdata),
`ifdef BRIDGE_ARB_LOCK_EN
    .io_m_lock       (m_lock),
`endif
    .io_m_ack        (io_m_ack),
    .io_m_rdata      (io_m_rdata),
    .io_busy         (io_busy),
    .io_bus_in_data  (io_bus_in_data),
    .io_bus_write    (io_bus_write),
    .io_bus_address  (io_bus_address),
    .io_bus_out_data (io_bus_out_data)
  );

  always @(posedge clk)
    if (io_bus_write && io_bus_address == 32'h0) r_periph <= io_bus_in_data;

  assign io_bus_out_data = (io_bus_address == 32'h4) ? 32'h0000_0539 :
                           (io_bus_address == 32'h0) ? r_periph : 32'h0;

  // Drives one single-master transaction and reports what came back.
  task automatic do_txn(input int m, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [1:0] ack_seen,
                        output logic [31:0] rdata, output int lat, output int wr_cycles);
    @(negedge clk);
    m_req = '0;
    m_req[m] = 1'b1;
    m_write[m] = wr;
    m_addr[m*32 +: 32] = addr;
    m_wdata[m*32 +: 32] = wdata;
    ack_seen = '0; rdata = '0; lat = -1; wr_cycles = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (io_bus_write) wr_cycles++;
      if (io_m_ack != 2'b00) begin
        ack_seen = io_m_ack; rdata = io_m_rdata; lat = k;
        m_req = '0;
        break;
      end
    end
    m_req = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; m_req = 2'b11; m_write = 2'b11; m_addr = '0; m_wdata = '1;
`ifdef BRIDGE_ARB_LOCK_EN
    m_lock = 2'b00;
`endif
    repeat (3) @(negedge clk);
    total++; if (io_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", io_busy); end
    total++; if (io_m_ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", io_m_ack); end
    total++; if (io_m_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", io_m_rdata); end
    total++; if (io_bus_write !== 1'b0) begin bad++; $display("FAIL reset_bus_write got=%b exp=0", io_bus_write); end
    total++; if (io_bus_address !== 32'h0) begin bad++; $display("FAIL reset_bus_addr got=%h exp=0", io_bus_address); end
    total++; if (io_bus_in_data !== 32'h0) begin bad++; $display("FAIL reset_bus_data got=%h exp=0", io_bus_in_data); end
    m_req = 2'b00; m_write = 2'b00; m_wdata = '0;
    reset = 1'b0;
  endtask

  task automatic test_simultaneous();
    int k0 = -1, k1 = -1;
    m_req = 2'b11; m_write = 2'b00; m_addr = {32'h4, 32'h4};
    for (int k = 1; k <= 12 && (k0 < 0 || k1 < 0); k++) begin
      @(negedge clk);
      if (io_m_ack[0]) begin k0 = k; m_req[0] = 1'b0; end
      if (io_m_ack[1]) begin k1 = k; m_req[1] = 1'b0; end
    end
    m_req = 2'b00;
    total++; if (k0 !== 2) begin bad++; $display("FAIL sim_ack0_cycle got=%0d exp=2", k0); end
    total++; if (k1 !== 5) begin bad++; $display("FAIL sim_ack1_cycle got=%0d exp=5", k1); end
  endtask

  task automatic test_write_read();
    logic [1:0] a; logic [31:0] d; int lat, wc;
    do_txn(0, 1'b1, 32'h0, 32'hDEAD_BEEF, a, d, lat, wc);
    total++; if (a !== 2'b01) begin bad++; $display("FAIL wr_ack got=%b exp=01", a); end
    total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    total++; if (wc !== 1) begin bad++; $display("FAIL wr_write_cycles got=%0d exp=1", wc); end
    do_txn(0, 1'b0, 32'h0, 32'h0, a, d, lat, wc);
    total++; if (a !== 2'b01) begin bad++; $display("FAIL rd_ack got=%b exp=01", a); end
    total++; if (lat !== 2) begin bad++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    total++; if (wc !== 0) begin bad++; $display("FAIL rd_write_cycles got=%0d exp=0", wc); end
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", d); end
  endtask

  task automatic test_const_read();
    logic [1:0] a; logic [31:0] d; int lat, wc;
    do_txn(1, 1'b0, 32'h4, 32'h0, a, d, lat, wc);
    total++; if (a !== 2'b10) begin bad++; $display("FAIL const_ack got=%b exp=10", a); end
    total++; if (d !== 32'h0000_0539) begin bad++; $display("FAIL const_data got=%h exp=00000539", d); end
  endtask

  task automatic test_continuous();
    int n = 0, last_k = 0, idle = 0;
    @(negedge clk);
    m_req = 2'b11; m_write = 2'b00; m_addr = {32'h0, 32'h4};
    for (int k = 1; k <= 40 && n < 6; k++) begin
      @(negedge clk);
      if (n > 0 && !io_busy) idle++;
      if (io_m_ack != 2'b00) begin
        total++;
        if (io_m_ack !== ((n % 2 == 0) ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL cont_grant%0d got=%b exp=%b", n, io_m_ack, (n % 2 == 0) ? 2'b01 : 2'b10);
        end
        if (n > 0) begin
          total++;
          if (k - last_k !== 3) begin bad++; $display("FAIL cont_gap%0d got=%0d exp=3", n, k - last_k); end
        end
        last_k = k;
        n++;
        if (n == 6) m_req = 2'b00;
      end
    end
    m_req = 2'b00;
    total++; if (n !== 6) begin bad++; $display("FAIL cont_count got=%0d exp=6", n); end
    total++; if (idle !== 5) begin bad++; $display("FAIL cont_idle got=%0d exp=5", idle); end
  endtask

  task automatic test_reset_issue();
    logic [1:0] a; logic [31:0] d; int lat, wc;
    do_txn(0, 1'b1, 32'h0, 32'h1111_1111, a, d, lat, wc);
    total++; if (a !== 2'b01) begin bad++; $display("FAIL rst_pre_ack got=%b exp=01", a); end
    @(negedge clk);
    m_req = 2'b01; m_write = 2'b01; m_addr[31:0] = 32'h0; m_wdata[31:0] = 32'h0000_1234;
    @(negedge clk);
    total++; if (io_bus_write !== 1'b1) begin bad++; $display("FAIL rst_issue_write got=%b exp=1", io_bus_write); end
    reset = 1'b1; m_req = 2'b00;
    #1;
    total++; if (io_bus_write !== 1'b0) begin bad++; $display("FAIL rst_gated_write got=%b exp=0", io_bus_write); end
    @(negedge clk);
    total++; if (io_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", io_busy); end
    total++; if (io_m_ack !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b exp=00", io_m_ack); end
    total++; if (io_m_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", io_m_rdata); end
    reset = 1'b0;
    do_txn(0, 1'b0, 32'h0, 32'h0, a, d, lat, wc);
    total++; if (a !== 2'b01) begin bad++; $display("FAIL rst_read_ack got=%b exp=01", a); end
    total++; if (d !== 32'h1111_1111) begin bad++; $display("FAIL rst_read_data got=%h exp=11111111", d); end
  endtask

`ifdef BRIDGE_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] a; logic [31:0] d; int lat, wc;
    logic [1:0] exp_g [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    int n = 0;
    do_txn(1, 1'b0, 32'h4, 32'h0, a, d, lat, wc);
    total++; if (a !== 2'b10) begin bad++; $display("FAIL lock_pre_ack got=%b exp=10", a); end
    @(negedge clk);
    m_req = 2'b11; m_write = 2'b00; m_addr = {32'h4, 32'h4}; m_lock = 2'b01;
    for (int k = 1; k <= 30 && n < 4; k++) begin
      @(negedge clk);
      if (io_m_ack != 2'b00) begin
        total++;
        if (io_m_ack !== exp_g[n]) begin bad++; $display("FAIL lock_grant%0d got=%b exp=%b", n, io_m_ack, exp_g[n]); end
        n++;
        if (n == 3) m_lock = 2'b00;
        if (n == 4) m_req = 2'b00;
      end
    end
    m_req = 2'b00;
    total++; if (n !== 4) begin bad++; $display("FAIL lock_count got=%0d exp=4", n); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_simultaneous();
    test_write_read();
    test_const_read();
    test_continuous();
    test_reset_issue();
`ifdef BRIDGE_ARB_LOCK_EN
    test_lock();
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bridge_arbiter.md
Name: bridge_arbiter

Overview:
Round-robin arbiter that shares the single-master peripheral bridge bus (in_data / write / address / out_data) between N requesting masters. It latches one master's request, drives that request onto the bridge for exactly one cycle, captures the read data, and returns a one-cycle ack with the data. It sits directly upstream of the bridge. The bridge and its peripherals are unchanged.

Parameters:
N_MASTERS, 2, number of requesting masters (>=2)
ADDR_W, 32, bridge address width
DATA_W, 32, bridge data width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
io_m_req  in  N_MASTERS  per-master request, held until ack
io_m_write  in  N_MASTERS  per-master 1=write, 0=read
io_m_addr  in  N_MASTERS*ADDR_W  per-master address, master i at slice [i*ADDR_W +: ADDR_W]
io_m_wdata  in  N_MASTERS*DATA_W  per-master write data, same slicing
io_m_ack  out  N_MASTERS  one-hot, one-cycle completion pulse
io_m_rdata  out  DATA_W  captured bridge read data, valid while any ack is high
io_busy  out  1  high whenever state != IDLE
io_bus_in_data  out  DATA_W  to bridge io_in_data
io_bus_write  out  1  to bridge io_write
io_bus_address  out  ADDR_W  to bridge io_address
io_bus_out_data  in  DATA_W  from bridge io_out_data (combinational read)

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: state=IDLE, last-grant pointer=N_MASTERS-1 (master 0 has first priority), io_m_ack=0, io_m_rdata=0, latched addr/wdata/write=0, io_busy=0. io_bus_* outputs read 0.
- FSM states: IDLE, ISSUE, ACK. A transaction takes exactly 3 cycles. Maximum throughput is 1 transaction per 3 cycles.
- IDLE, with any io_m_req high:
  - Pick the winner: first requester found searching from pointer+1 upward, with wrap-around.
  - Latch the winner's index, addr, wdata and write.
  - Next state is ISSUE. With no request, remain in IDLE.
- ISSUE:
  - io_bus_address and io_bus_in_data are driven from the latched values.
  - io_bus_write = latched write & ~reset.
  - io_bus_out_data is registered into io_m_rdata at the end of the cycle. This happens for writes too; rdata is "don't care" for writes.
  - Next state is ACK.
- Outside ISSUE: io_bus_write=0, io_bus_address=0, io_bus_in_data=0.
- ACK:
  - io_m_ack[winner]=1 for this one cycle only.
  - pointer <= winner.
  - Next state is IDLE.
- Master rule: drop req in the cycle after ack. A req still high when IDLE samples it counts as a new request.
- Req deasserted after latch: the transaction still completes and the ack is still issued.
- Simultaneous requests: resolved purely by the round-robin pointer. No starvation: any requester waits at most N_MASTERS-1 transactions.
- Reset during ISSUE or ACK:
  - The transaction is aborted; no ack is issued.
  - io_bus_write is gated low in the reset cycle, so the peripheral is not written.
  - Returns to IDLE with reset values.
- Inputs outside ISSUE are ignored except io_m_req, io_m_write, io_m_addr and io_m_wdata sampled in IDLE.

Optional Feature:
BRIDGE_ARB_LOCK_EN
- Defined:
  - Adds input io_m_lock [N_MASTERS].
  - If the winner's lock bit is high during its ACK cycle, the next IDLE considers only that master.
  - If that master's req is low in that IDLE, the lock is released and normal round-robin applies in the same cycle.
  - A locked sequence may exceed the starvation bound.
- Undefined: port absent; pure round-robin as above.

Decomposition:
- Package bridge_arb_pkg: state enum (IDLE, ISSUE, ACK) and default width constants ADDR_W_DEF=32 and DATA_W_DEF=32.
- Sub-module rr_pick:
  - Combinational; inputs: req vector, pointer.
  - Outputs: winner index and any_req.
  - Reused by other arbiters.

Test Plan:
- Write then read: master0 writes 0xDEADBEEF to addr 0, then reads addr 0 -> io_bus_write high exactly 1 cycle (ISSUE); each ack 2 cycles after the latch edge; read rdata=0xDEADBEEF.
- Constant peripheral read: master1 reads addr 4 -> io_m_ack[1] pulses and io_m_rdata=0x00000539.
- Simultaneous requests right after reset: master0 and master1 both request -> master0 acked first (cycle 3), master1 next (cycle 6).
- Continuous requests: both hold req across 6 transactions -> grants alternate 0,1,0,1,0,1; io_busy high throughout except single IDLE cycles.
- Reset in ISSUE: reg=0x11111111, then reset asserted during ISSUE of master0 write 0x00001234 to addr 0 -> no ack; io_bus_write low that cycle; a later read of addr 0 returns 0x11111111.
- Lock (BRIDGE_ARB_LOCK_EN): master0 lock=1 with both requesting for 3 transactions -> master0 acked 3 times consecutively; after lock=0, master1 is granted next.
